// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one 16-bit memory port between instruction fetch and data access.
// Optional round-robin contention policy: define MEM_ARB_ROUND_ROBIN_EN (default is data-first priority).
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        data_m_access,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_m_access,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BSEL_W = 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_last_grant;
  logic       w_prefer_d;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_ack_i;
  logic       w_ack_d;

  // Contention policy: who wins when both requesters are high in IDLE.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_prefer_d = (r_last_grant == LG_I);
`else
  assign w_prefer_d = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and grant-entry decode.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_m_access && (!instr_m_access || w_prefer_d)) begin
          w_grant_d    = 1'b1;
          w_next_state = S_GRANT_D;
        end else if (instr_m_access) begin
          w_grant_i    = 1'b1;
          w_next_state = S_GRANT_I;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (q_m_ack) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant history, recorded on every grant entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= LG_I;
    end else if (w_grant_i) begin
      r_last_grant <= LG_I;
    end else if (w_grant_d) begin
      r_last_grant <= LG_D;
    end
  end

  // Shared-port fields: latched on grant entry, held until ack; only access drops after ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_m_addr     <= '0;
      q_m_data_out <= '0;
      q_m_wr_en    <= 1'b0;
      q_m_bytesel  <= '0;
      q_m_access   <= 1'b0;
    end else if (w_grant_i) begin
      q_m_addr     <= instr_m_addr;
      q_m_data_out <= '0;
      q_m_wr_en    <= 1'b0;
      q_m_bytesel  <= BSEL_W'(2'b11);
      q_m_access   <= 1'b1;
    end else if (w_grant_d) begin
      q_m_addr     <= data_m_addr;
      q_m_data_out <= data_m_data_out;
      q_m_wr_en    <= data_m_wr_en;
      q_m_bytesel  <= data_m_bytesel;
      q_m_access   <= 1'b1;
    end else if ((r_state != S_IDLE) && q_m_ack) begin
      q_m_access   <= 1'b0;
    end
  end

  // Ack steering is zero-latency; an ack seen in IDLE is dropped.
  assign w_ack_i = (r_state == S_GRANT_I) && q_m_ack;
  assign w_ack_d = (r_state == S_GRANT_D) && q_m_ack;

  assign instr_m_ack     = w_ack_i;
  assign data_m_ack      = w_ack_d;
  assign instr_m_data_in = w_ack_i ? q_m_data_in : DATA_W'(0);
  assign data_m_data_in  = w_ack_d ? q_m_data_in : DATA_W'(0);

  // Grant history must agree with the grant currently held.
  a_last_grant_i: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_GRANT_I) |-> (r_last_grant == LG_I));
  a_last_grant_d: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_GRANT_D) |-> (r_last_grant == LG_D));

  // Address width sanity against the port declaration.
  a_addr_w: assert property (@(posedge clk) disable iff (!reset)
    ($bits(q_m_addr) == ADDR_W));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus contention, async-reset and spurious-ack sequences.
// Contention expectations follow MEM_ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [18:0] instr_m_addr;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        data_m_access;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_access;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  int total;
  int bad;

  mem_bus_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .instr_m_addr    (instr_m_addr),
    .instr_m_access  (instr_m_access),
    .instr_m_ack     (instr_m_ack),
    .instr_m_data_in (instr_m_data_in),
    .data_m_addr     (data_m_addr),
    .data_m_data_out (data_m_data_out),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .data_m_data_in  (data_m_data_in),
    .q_m_addr        (q_m_addr),
    .q_m_data_out    (q_m_data_out),
    .q_m_wr_en       (q_m_wr_en),
    .q_m_bytesel     (q_m_bytesel),
    .q_m_access      (q_m_access),
    .q_m_ack         (q_m_ack),
    .q_m_data_in     (q_m_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ia;
    logic [18:0] iaddr;
    logic        da;
    logic [18:0] daddr;
    logic [15:0] dout;
    logic        dwr;
    logic [1:0]  dbs;
    logic        qack;
    logic [15:0] qdin;
    logic        e_qacc;
    logic [18:0] e_qaddr;
    logic [15:0] e_qdout;
    logic        e_qwr;
    logic [1:0]  e_qbs;
    logic        e_iack;
    logic [15:0] e_idat;
    logic        e_dack;
    logic [15:0] e_ddat;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_m_access  = 1'b0;
    instr_m_addr    = '0;
    data_m_access   = 1'b0;
    data_m_addr     = '0;
    data_m_data_out = '0;
    data_m_wr_en    = 1'b0;
    data_m_bytesel  = '0;
    q_m_ack         = 1'b0;
    q_m_data_in     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " q_m_access"},      32'(q_m_access),      32'd0);
    chk({tag, " q_m_addr"},        32'(q_m_addr),        32'd0);
    chk({tag, " q_m_data_out"},    32'(q_m_data_out),    32'd0);
    chk({tag, " q_m_wr_en"},       32'(q_m_wr_en),       32'd0);
    chk({tag, " q_m_bytesel"},     32'(q_m_bytesel),     32'd0);
    chk({tag, " instr_m_ack"},     32'(instr_m_ack),     32'd0);
    chk({tag, " data_m_ack"},      32'(data_m_ack),      32'd0);
    chk({tag, " instr_m_data_in"}, 32'(instr_m_data_in), 32'd0);
    chk({tag, " data_m_data_in"},  32'(data_m_data_in),  32'd0);
  endtask

  // Contention: both requesters held high; memory acks in the first grant cycle.
  task automatic run_contention();
    int   grants;
    int   idle;
    int   cyc;
    logic won_d [4];
    logic exp_d;
    do_reset();
    instr_m_access  = 1'b1;
    instr_m_addr    = 19'h11111;
    data_m_access   = 1'b1;
    data_m_addr     = 19'h22222;
    data_m_data_out = 16'hAAAA;
    data_m_wr_en    = 1'b0;
    data_m_bytesel  = 2'b11;
    grants = 0;
    idle   = 0;
    cyc    = 0;
    step();
    while (grants < 4 && cyc < 40) begin
      if (q_m_access) begin
        won_d[grants] = (q_m_addr == 19'h22222);
        q_m_ack     = 1'b1;
        q_m_data_in = 16'h1000 + 16'(grants);
        #1;
        if (won_d[grants]) begin
          chk($sformatf("cont%0d data_m_ack", grants), 32'(data_m_ack), 32'd1);
          chk($sformatf("cont%0d instr_m_ack", grants), 32'(instr_m_ack), 32'd0);
          chk($sformatf("cont%0d data_m_data_in", grants), 32'(data_m_data_in), 32'h1000 + 32'(grants));
        end else begin
          chk($sformatf("cont%0d instr_m_ack", grants), 32'(instr_m_ack), 32'd1);
          chk($sformatf("cont%0d data_m_ack", grants), 32'(data_m_ack), 32'd0);
          chk($sformatf("cont%0d instr_m_data_in", grants), 32'(instr_m_data_in), 32'h1000 + 32'(grants));
        end
        if (grants > 0) chk($sformatf("cont%0d idle gap", grants), 32'(idle), 32'd1);
        grants++;
        idle = 0;
      end else begin
        idle++;
      end
      step();
      q_m_ack = 1'b0;
      cyc++;
    end
    chk("cont grant count", 32'(grants), 32'd4);
    for (int k = 0; k < grants; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = ((k % 2) == 0);
`else
      exp_d = 1'b1;
`endif
      chk($sformatf("cont%0d winner_is_d", k), 32'(won_d[k]), 32'(exp_d));
    end
    idle_inputs();
  endtask

  // Async reset in GRANT_D, then a late ack that must be ignored.
  task automatic run_async_reset();
    do_reset();
    data_m_access   = 1'b1;
    data_m_addr     = 19'h00ABC;
    data_m_data_out = 16'h5A5A;
    data_m_wr_en    = 1'b1;
    data_m_bytesel  = 2'b10;
    step();
    step();
    chk("rst pre q_m_access", 32'(q_m_access), 32'd1);
    chk("rst pre q_m_addr", 32'(q_m_addr), 32'h00ABC);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst during");
    data_m_access = 1'b0;
    step();
    reset = 1'b1;
    step();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hDEAD;
    #1;
    chk("rst late data_m_ack", 32'(data_m_ack), 32'd0);
    chk("rst late instr_m_ack", 32'(instr_m_ack), 32'd0);
    chk("rst late data_m_data_in", 32'(data_m_data_in), 32'd0);
    step();
    q_m_ack        = 1'b0;
    instr_m_access = 1'b1;
    instr_m_addr   = 19'h00042;
    step();
    chk("rst post idle grant q_m_access", 32'(q_m_access), 32'd1);
    chk("rst post idle grant q_m_addr", 32'(q_m_addr), 32'h00042);
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            ia iaddr       da daddr       dout     wr  bs     qa qdin      | qacc qaddr      qdout    qwr qbs   iack idat      dack ddat
    vecs[0]  = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,    0, 16'h0};
    vecs[1]  = '{1, 19'h0FFF8, 0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,    0, 16'h0};
    vecs[2]  = '{1, 19'h0FFF8, 0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     1, 19'h0FFF8, 16'h0,    0, 2'b11, 0, 16'h0,    0, 16'h0};
    vecs[3]  = '{1, 19'h0FFF8, 0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     1, 19'h0FFF8, 16'h0,    0, 2'b11, 0, 16'h0,    0, 16'h0};
    vecs[4]  = '{1, 19'h0FFF8, 0, 19'h0,     16'h0,    0, 2'b00, 1, 16'hBEEF,  1, 19'h0FFF8, 16'h0,    0, 2'b11, 1, 16'hBEEF, 0, 16'h0};
    vecs[5]  = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'hBEEF,  0, 19'h0FFF8, 16'h0,    0, 2'b11, 0, 16'h0,    0, 16'h0};
    vecs[6]  = '{0, 19'h0,     1, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,     0, 19'h0FFF8, 16'h0,    0, 2'b11, 0, 16'h0,    0, 16'h0};
    vecs[7]  = '{0, 19'h0,     1, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,     1, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,    0, 16'h0};
    vecs[8]  = '{0, 19'h0,     1, 19'h00010, 16'h1234, 1, 2'b01, 1, 16'h5555,  1, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,    1, 16'h5555};
    vecs[9]  = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     0, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,    0, 16'h0};
    vecs[10] = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 1, 16'h7777,  0, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,    0, 16'h0};
    vecs[11] = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     0, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,    0, 16'h0};
    vecs[12] = '{1, 19'h00001, 0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     0, 19'h00010, 16'h1234, 1, 2'b01, 0, 16'h0,    0, 16'h0};
    vecs[13] = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     1, 19'h00001, 16'h0,    0, 2'b11, 0, 16'h0,    0, 16'h0};
    vecs[14] = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 1, 16'h0001,  1, 19'h00001, 16'h0,    0, 2'b11, 1, 16'h0001, 0, 16'h0};
    vecs[15] = '{0, 19'h0,     0, 19'h0,     16'h0,    0, 2'b00, 0, 16'h0,     0, 19'h00001, 16'h0,    0, 2'b11, 0, 16'h0,    0, 16'h0};

    idle_inputs();
    reset = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      instr_m_access  = vecs[i].ia;
      instr_m_addr    = vecs[i].iaddr;
      data_m_access   = vecs[i].da;
      data_m_addr     = vecs[i].daddr;
      data_m_data_out = vecs[i].dout;
      data_m_wr_en    = vecs[i].dwr;
      data_m_bytesel  = vecs[i].dbs;
      q_m_ack         = vecs[i].qack;
      q_m_data_in     = vecs[i].qdin;
      #1;
      chk($sformatf("v%0d q_m_access", i),      32'(q_m_access),      32'(vecs[i].e_qacc));
      chk($sformatf("v%0d q_m_addr", i),        32'(q_m_addr),        32'(vecs[i].e_qaddr));
      chk($sformatf("v%0d q_m_data_out", i),    32'(q_m_data_out),    32'(vecs[i].e_qdout));
      chk($sformatf("v%0d q_m_wr_en", i),       32'(q_m_wr_en),       32'(vecs[i].e_qwr));
      chk($sformatf("v%0d q_m_bytesel", i),     32'(q_m_bytesel),     32'(vecs[i].e_qbs));
      chk($sformatf("v%0d instr_m_ack", i),     32'(instr_m_ack),     32'(vecs[i].e_iack));
      chk($sformatf("v%0d instr_m_data_in", i), 32'(instr_m_data_in), 32'(vecs[i].e_idat));
      chk($sformatf("v%0d data_m_ack", i),      32'(data_m_ack),      32'(vecs[i].e_dack));
      chk($sformatf("v%0d data_m_data_in", i),  32'(data_m_data_in),  32'(vecs[i].e_ddat));
      step();
    end
    idle_inputs();

    run_contention();
    run_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
